psola_out_streamer: RTL and testbench

- Downstream of the PSOLA synthesis stage.
- Captures each completed synthesis frame: a Q10 fixed-point array plus its valid length, latched on the synthesis done pulse.
- Plays the frame back one sample per audio sample tick, as a saturated 16-bit stream for the DAC/I2S path.
- Double-buffered, so the next frame is absorbed while the current one plays. Reports underrun and overrun.

---
 rtl/psola_out_streamer_if.sv | 30 +++
 rtl/psola_out_streamer.sv | 166 ++++++++++++++++
 tb/tb_psola_out_streamer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psola_out_streamer_if.sv
// Bus between the PSOLA synthesis stage, the audio tick source and psola_out_streamer.
// Carries the frame capture inputs, the playback stream outputs and the FSM debug state.
interface psola_out_streamer_if #(
    parameter int WINDOW_SIZE = 2048,
    parameter int OUT_WIDTH   = 16
);
    // Strobe semantics, no backpressure: frame_in/frame_len_in are sampled only on the
    // cycle frame_done_in is high. sample_valid_out pulses exactly one cycle after every
    // sample_tick_in, and sample_out then holds until the next pulse.
    logic                        frame_done_in;
    logic signed [31:0]          frame_in [2*WINDOW_SIZE];
    logic [11:0]                 frame_len_in;
    logic                        sample_tick_in;
    logic signed [OUT_WIDTH-1:0] sample_out;
    logic                        sample_valid_out;
    logic                        playing_out;
    logic                        underrun_out;
    logic                        overrun_out;
    logic                        state_dbg;

    modport master (
        output frame_done_in, frame_in, frame_len_in, sample_tick_in,
        input  sample_out, sample_valid_out, playing_out, underrun_out, overrun_out, state_dbg
    );

    modport slave (
        input  frame_done_in, frame_in, frame_len_in, sample_tick_in,
        output sample_out, sample_valid_out, playing_out, underrun_out, overrun_out, state_dbg
    );
endinterface

// File: rtl/psola_out_streamer.sv
// Double-buffered PSOLA frame player: captures Q10 frames and streams them one sample per tick.
// PSOLA_OUT_SATURATE_EN: clamp to OUT_WIDTH instead of two's-complement wrap.
module psola_out_streamer #(
    parameter int WINDOW_SIZE = 2048,
    parameter int FRAC_BITS   = 10,
    parameter int OUT_WIDTH   = 16
) (
    input logic               clk_in,
    input logic               rst_n_in,
    psola_out_streamer_if.slave bus
);
    localparam int          DEPTH   = 2 * WINDOW_SIZE;
    localparam int          IDX_W   = $clog2(DEPTH) + 1;
    localparam int          ADDR_W  = IDX_W - 1;
    localparam logic [31:0] DEPTH_U = DEPTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [31:0] bank0 [DEPTH];
    logic signed [31:0] bank1 [DEPTH];

    logic [IDX_W-1:0]  index_q, active_len_q, pending_len_q, cap_len;
    logic [31:0]       len_ext;
    logic              pending_valid_q, active_sel_q, played_q;
    logic              cap_en, promote, idle_empty, last_sample, playing;
    logic              wr_sel, rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic signed [31:0]          rd_word;
    logic signed [OUT_WIDTH-1:0] conv;
    logic signed [OUT_WIDTH-1:0] sample_q;
    logic              sample_valid_q, underrun_q, overrun_q;

    // Zero-length pulses are dropped; longer-than-storage frames are clamped.
    always_comb begin
        len_ext = 32'(bus.frame_len_in);
        cap_len = (len_ext > DEPTH_U) ? IDX_W'(DEPTH) : IDX_W'(len_ext);
        cap_en  = bus.frame_done_in && (bus.frame_len_in != '0);
    end

    assign last_sample = (index_q == active_len_q - IDX_W'(1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A one-sample frame is fully played by its promoting tick.
                if (bus.sample_tick_in && pending_valid_q && (pending_len_q != IDX_W'(1)))
                    state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.sample_tick_in && last_sample && !pending_valid_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        promote    = 1'b0;
        playing    = 1'b0;
        idle_empty = 1'b0;
        rd_sel     = active_sel_q;
        rd_addr    = index_q[ADDR_W-1:0];
        case (state_q)
            ST_IDLE: begin
                promote    = bus.sample_tick_in && pending_valid_q;
                idle_empty = !pending_valid_q;
                rd_sel     = ~active_sel_q;
                rd_addr    = '0;
            end
            ST_PLAY: begin
                playing = 1'b1;
                promote = bus.sample_tick_in && last_sample && pending_valid_q;
            end
            default: ;
        endcase
    end

    // On a promote the old active bank becomes the pending bank, so a same-cycle capture lands there.
    assign wr_sel = promote ? active_sel_q : ~active_sel_q;

    always_ff @(posedge clk_in) begin
        if (cap_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel) bank1[i] <= bus.frame_in[i];
                else        bank0[i] <= bus.frame_in[i];
            end
        end
    end

    assign rd_word = rd_sel ? bank1[rd_addr] : bank0[rd_addr];

`ifdef PSOLA_OUT_SATURATE_EN
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_WIDTH - 1));
    logic signed [31:0] shifted;

    always_comb begin
        shifted = rd_word >>> FRAC_BITS;
        if (shifted > SAT_MAX)      conv = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN) conv = SAT_MIN[OUT_WIDTH-1:0];
        else                        conv = shifted[OUT_WIDTH-1:0];
    end
`else
    assign conv = OUT_WIDTH'(rd_word >>> FRAC_BITS);
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sample_q        <= '0;
            sample_valid_q  <= 1'b0;
            underrun_q      <= 1'b0;
            overrun_q       <= 1'b0;
            index_q         <= '0;
            active_len_q    <= '0;
            pending_len_q   <= '0;
            pending_valid_q <= 1'b0;
            active_sel_q    <= 1'b0;
            played_q        <= 1'b0;
        end else begin
            sample_valid_q <= bus.sample_tick_in;
            if (bus.sample_tick_in) begin
                sample_q <= idle_empty ? '0 : conv;
                if (idle_empty && played_q)
                    underrun_q <= 1'b1;
                if (state_q == ST_IDLE) begin
                    if (pending_valid_q) index_q <= IDX_W'(1);
                end else if (last_sample) begin
                    index_q <= '0;
                end else begin
                    index_q <= index_q + IDX_W'(1);
                end
            end
            if (promote) begin
                active_sel_q    <= ~active_sel_q;
                active_len_q    <= pending_len_q;
                pending_valid_q <= 1'b0;
                played_q        <= 1'b1;
            end
            // Capture after promote so a same-cycle frame becomes the new pending one.
            if (cap_en) begin
                pending_valid_q <= 1'b1;
                pending_len_q   <= cap_len;
                if (pending_valid_q && !promote)
                    overrun_q <= 1'b1;
            end
        end
    end

    assign bus.sample_out       = sample_q;
    assign bus.sample_valid_out = sample_valid_q;
    assign bus.playing_out      = playing;
    assign bus.underrun_out     = underrun_q;
    assign bus.overrun_out      = overrun_q;
    assign bus.state_dbg        = state_q;
endmodule

// File: tb/tb_psola_out_streamer.sv
// Bench for psola_out_streamer: table-driven conversion vectors plus playback corner sequences.
// A small window (depth 16) keeps the length clamp reachable with the 12-bit length field.
module tb_psola_out_streamer;
    localparam int WS    = 8;
    localparam int DEPTH = 2 * WS;

    logic clk;
    logic rst_n;

    psola_out_streamer_if #(.WINDOW_SIZE(WS), .OUT_WIDTH(16)) bus ();

    psola_out_streamer #(.WINDOW_SIZE(WS), .FRAC_BITS(10), .OUT_WIDTH(16)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic signed [31:0] word;
        logic signed [15:0] exp;
    } vec_t;

    logic signed [15:0] exp_q[$];
    logic signed [31:0] fr [DEPTH];
    vec_t               vecs [10];
    logic               tick_q;
    int                 n_checks;
    int                 n_fail;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic clear_fr();
        for (int i = 0; i < DEPTH; i++) fr[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_frame(input int len);
        @(negedge clk);
        bus.frame_in      = fr;
        bus.frame_len_in  = 12'(len);
        bus.frame_done_in = 1'b1;
        @(negedge clk);
        bus.frame_done_in = 1'b0;
    endtask

    task automatic tick(input logic signed [15:0] exp);
        @(negedge clk);
        bus.sample_tick_in = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.sample_tick_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick_and_send(input int len, input logic signed [15:0] exp);
        @(negedge clk);
        bus.sample_tick_in = 1'b1;
        bus.frame_in       = fr;
        bus.frame_len_in   = 12'(len);
        bus.frame_done_in  = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.sample_tick_in = 1'b0;
        bus.frame_done_in  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard: every valid pulse pops one expected sample; pulses must trail ticks by one cycle.
    always @(posedge clk) tick_q <= bus.sample_tick_in;

    always @(negedge clk) begin
        if (rst_n && (tick_q || bus.sample_valid_out))
            check("valid_timing", int'(bus.sample_valid_out), int'(tick_q));
        if (rst_n && bus.sample_valid_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sample_unexpected: got %0d with nothing queued", bus.sample_out);
            end else begin
                check("sample", int'(bus.sample_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        tick_q   = 1'b0;
        clear_fr();
        bus.frame_in       = fr;
        bus.frame_done_in  = 1'b0;
        bus.frame_len_in   = '0;
        bus.sample_tick_in = 1'b0;

        vecs[0] = '{32'sd1024,       16'sd1};
        vecs[1] = '{32'sd2048,       16'sd2};
        vecs[2] = -32'sd1024 == -32'sd1024 ? '{-32'sd1024, -16'sd1} : '{0, 0};
        vecs[3] = '{32'sd5120,       16'sd5};
        vecs[4] = '{32'sd1023,       16'sd0};
        vecs[5] = '{-32'sd1,         -16'sd1};
        vecs[6] = '{32'sd33553408,   16'sd32767};
`ifdef PSOLA_OUT_SATURATE_EN
        vecs[7] = '{32'sh7FFFFC00,   16'sd32767};
        vecs[8] = '{32'sh80000000,   -16'sd32768};
        vecs[9] = '{32'sd33554432,   16'sd32767};
`else
        vecs[7] = '{32'sh7FFFFC00,   -16'sd1};
        vecs[8] = '{32'sh80000000,   16'sd0};
        vecs[9] = '{32'sd33554432,   -16'sd32768};
`endif

        // Reset held: all outputs low
        repeat (3) @(negedge clk);
        check("rst_sample", int'(bus.sample_out), 0);
        check("rst_valid", int'(bus.sample_valid_out), 0);
        check("rst_playing", int'(bus.playing_out), 0);
        check("rst_underrun", int'(bus.underrun_out), 0);
        check("rst_overrun", int'(bus.overrun_out), 0);
        check("rst_state", int'(bus.state_dbg), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Startup silence is not an underrun
        for (int i = 0; i < 3; i++) tick(16'sd0);
        check("idle_underrun", int'(bus.underrun_out), 0);
        check("idle_playing", int'(bus.playing_out), 0);

        // Basic playback
        do_reset();
        clear_fr();
        fr[0] = 32'sd1024; fr[1] = 32'sd2048; fr[2] = -32'sd1024; fr[3] = 32'sd5120;
        send_frame(4);
        tick(16'sd1);
        check("basic_playing", int'(bus.playing_out), 1);
        tick(16'sd2);
        tick(-16'sd1);
        tick(16'sd5);
        repeat (3) @(negedge clk);
        check("basic_hold", int'(bus.sample_out), 5);
        check("basic_underrun_pre", int'(bus.underrun_out), 0);
        tick(16'sd0);
        check("basic_underrun", int'(bus.underrun_out), 1);
        check("basic_idle", int'(bus.playing_out), 0);

        // Conversion table
        do_reset();
        clear_fr();
        for (int i = 0; i < 10; i++) fr[i] = vecs[i].word;
        send_frame(10);
        for (int i = 0; i < 10; i++) tick(vecs[i].exp);
        tick(16'sd0);

        // Gapless switch
        do_reset();
        clear_fr();
        fr[0] = 32'sd3072; fr[1] = 32'sd4096; fr[2] = 32'sd6144;
        send_frame(3);
        tick(16'sd3);
        clear_fr();
        fr[0] = -32'sd2048; fr[1] = -32'sd3072;
        send_frame(2);
        tick(16'sd4);
        tick(16'sd6);
        tick(-16'sd2);
        tick(-16'sd3);
        check("gapless_overrun", int'(bus.overrun_out), 0);
        check("gapless_underrun", int'(bus.underrun_out), 0);
        tick(16'sd0);

        // Overrun: three frames while A plays, only the last survives
        do_reset();
        clear_fr();
        fr[0] = 32'sd1024; fr[1] = 32'sd2048; fr[2] = 32'sd3072;
        send_frame(3);
        tick(16'sd1);
        fr[0] = 32'sd9216;  fr[1] = 32'sd10240; send_frame(2);
        check("overrun_first", int'(bus.overrun_out), 0);
        fr[0] = 32'sd11264; fr[1] = 32'sd12288; send_frame(2);
        fr[0] = 32'sd7168;  fr[1] = 32'sd8192;  send_frame(2);
        check("overrun_flag", int'(bus.overrun_out), 1);
        tick(16'sd2);
        tick(16'sd3);
        tick(16'sd7);
        tick(16'sd8);
        tick(16'sd0);

        // Same-cycle promote and capture: no overrun
        do_reset();
        clear_fr();
        fr[0] = 32'sd1024; fr[1] = 32'sd2048; send_frame(2);
        tick(16'sd1);
        fr[0] = 32'sd3072; fr[1] = 32'sd4096; send_frame(2);
        fr[0] = 32'sd5120; fr[1] = 32'sd0;
        tick_and_send(1, 16'sd2);
        tick(16'sd3);
        tick(16'sd4);
        tick(16'sd5);
        check("samecycle_overrun", int'(bus.overrun_out), 0);
        tick(16'sd0);
        check("samecycle_underrun", int'(bus.underrun_out), 1);

        // Zero-length pulses are ignored
        do_reset();
        clear_fr();
        fr[0] = 32'sd20480;
        send_frame(0);
        tick(16'sd0);
        check("len0_playing", int'(bus.playing_out), 0);
        check("len0_underrun", int'(bus.underrun_out), 0);
        fr[0] = 32'sd1024; fr[1] = 32'sd2048; send_frame(2);
        fr[0] = 32'sd30720; fr[1] = 32'sd30720; send_frame(0);
        tick(16'sd1);
        tick(16'sd2);
        tick(16'sd0);
        check("len0_overrun", int'(bus.overrun_out), 0);

        // Length clamp: 4095 plays exactly DEPTH samples
        do_reset();
        for (int i = 0; i < DEPTH; i++) fr[i] = 32'((i + 1) * 1024);
        send_frame(4095);
        for (int i = 0; i < DEPTH; i++) tick(16'(i + 1));
        check("clamp_underrun_pre", int'(bus.underrun_out), 0);
        tick(16'sd0);
        check("clamp_underrun", int'(bus.underrun_out), 1);

        // Async reset mid-playback
        do_reset();
        clear_fr();
        fr[0] = 32'sd102400; fr[1] = 32'sd204800; fr[2] = 32'sd307200; fr[3] = 32'sd409600;
        send_frame(4);
        tick(16'sd100);
        tick(16'sd200);
        check("mid_playing", int'(bus.playing_out), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_sample", int'(bus.sample_out), 0);
        check("async_playing", int'(bus.playing_out), 0);
        check("async_valid", int'(bus.sample_valid_out), 0);
        check("async_state", int'(bus.state_dbg), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick(16'sd0);
        check("noresume_playing", int'(bus.playing_out), 0);
        check("noresume_underrun", int'(bus.underrun_out), 0);

        // Final report
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
